// File: rtl/twiddle_index_seq_if.sv
// ---------------------------------------------------------------------------
// twiddle_index_seq_if
// Purpose : Bundles the request/response signals between the FFT stage
//           datapaths and the twiddle index sequencer.
// Signals : clear      - synchronous frame realign (requester -> sequencer)
//           stage_en   - per-stage sample consume strobe (requester -> sequencer)
//           indexes    - packed per-stage twiddle index (sequencer -> requester)
//           idx_valid  - per-stage index updated by previous cycle's enable
//           frame_last - per-stage flag: index belongs to last sample of frame
// Modports: master = stage datapaths, slave = sequencer.
// ---------------------------------------------------------------------------
interface twiddle_index_seq_if #(
    parameter int FFT_SIZE = 16
);
    localparam int S  = $clog2(FFT_SIZE);
    localparam int NS = S - 1;
    localparam int IW = S - 1;

    logic                   clear;
    logic [NS-1:0]          stage_en;
    logic [NS-1:0][IW-1:0]  indexes;
    logic [NS-1:0]          idx_valid;
    logic [NS-1:0]          frame_last;

    modport master (
        output clear,
        output stage_en,
        input  indexes,
        input  idx_valid,
        input  frame_last
    );

    modport slave (
        input  clear,
        input  stage_en,
        output indexes,
        output idx_valid,
        output frame_last
    );
endinterface

// File: rtl/twiddle_index_seq.sv
// ---------------------------------------------------------------------------
// twiddle_index_seq
// Purpose : Per-stage twiddle index sequencer for a radix-2 DIF single-path
//           FFT pipeline. Each twiddle-bearing stage owns an independent
//           sample counter; every enabled sample yields one registered index
//           (consumed by twiddles_gen) one cycle later. The final stage only
//           ever uses W^0 and therefore has no entry.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - twiddle_index_seq_if.slave (clear, stage_en in;
//                  indexes, idx_valid, frame_last out)
// ---------------------------------------------------------------------------
module twiddle_index_seq #(
    parameter int FFT_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    twiddle_index_seq_if.slave  bus
);
    localparam int S  = $clog2(FFT_SIZE);
    localparam int NS = S - 1;
    localparam int IW = S - 1;

    for (genvar g = 0; g < NS; g++) begin : gStage
        // Bit HIBIT of the sample counter selects the lower half of the
        // current butterfly span; the bits below it are the position k
        // within that half, scaled by 2^g to give W^(k*2^g).
        localparam int             HIBIT   = S - 1 - g;
        localparam logic [S-1:0]   LOWMASK = S'((1 << HIBIT) - 1);

        logic [S-1:0]  cnt_q, cnt_d;
        logic [IW-1:0] idx_q, idx_d;
        logic          vld_q, vld_d;
        logic          last_q, last_d;
        logic [IW-1:0] idx_f;

        // Masked position never uses the counter MSB, so narrowing to IW
        // bits before the shift loses nothing; the product stays below N/2.
        always_comb begin
            idx_f = '0;
            if (cnt_q[HIBIT]) begin
                idx_f = IW'(cnt_q & LOWMASK) << g;
            end
        end

        // clear wins over enable: the realign cycle discards any concurrent
        // sample so the next enable is sample 0 of a fresh frame.
        always_comb begin
            cnt_d  = cnt_q;
            idx_d  = idx_q;
            vld_d  = 1'b0;
            last_d = 1'b0;
            if (bus.clear) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (bus.stage_en[g]) begin
                idx_d  = idx_f;
                vld_d  = 1'b1;
                last_d = (cnt_q == S'(FFT_SIZE - 1));
                cnt_d  = cnt_q + S'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                idx_q  <= '0;
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                idx_q  <= idx_d;
                vld_q  <= vld_d;
                last_q <= last_d;
            end
        end

        assign bus.indexes[g]    = idx_q;
        assign bus.idx_valid[g]  = vld_q;
        assign bus.frame_last[g] = last_q;
    end

endmodule
